imem_load_ctrl: RTL

Load controller for the RV32I core's byte-addressed 128-byte instruction memory. It sequences the memory between two phases: a load phase, in which a host streams a program image byte by byte into the memory over a valid/ready interface with checksum verification, and a run phase, in which the core's fetch address drives the read port. The core is held stalled whenever the image is absent, loading, or failed verification. Fetch addresses are checked for alignment and range.

---
 rtl/imem_load_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: load/run sequencer for the core's byte-addressed instruction memory.
//
// A host streams a program image one byte per handshake into the memory. The image is
// verified against a mod-256 checksum before the core is released to fetch. While the
// image is absent, loading or bad, the core is stalled.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   load_start      - begin a load (honoured in HALT and RUN only)
//   load_len        - image length in bytes, latched with load_start
//   load_csum       - expected mod-256 byte sum, latched with load_start
//   s_valid/s_data  - host byte stream; s_ready asserted throughout LOAD
//   mem_we/mem_waddr/mem_wdata - registered imem write port
//   core_pc         - core fetch byte address
//   mem_raddr       - imem read address (core_pc in RUN, else 0)
//   core_stall      - core must hold its PC (HALT, LOAD, CHECK)
//   load_done       - one-cycle pulse on entry to RUN
//   load_err        - sticky length/checksum failure flag
//   fetch_fault     - registered misaligned/out-of-range fetch flag, RUN only
module imem_load_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [7:0]        load_csum,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  input  logic [ADDR_W-1:0] core_pc,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              core_stall,
  output logic              load_done,
  output logic              load_err,
  output logic              fetch_fault
);

  localparam logic [1:0] StHalt  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StRun   = 2'd3;

  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam int unsigned LenExtW  = LEN_W + 1;
  localparam int unsigned AddrExtW = ADDR_W + 1;
  localparam logic [LEN_W:0]  DepthLen = LenExtW'(Depth);
  // Highest address from which a full 32-bit word can still be fetched.
  localparam logic [ADDR_W:0] PcMax    = AddrExtW'(Depth - 4);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        sum_q, sum_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              fault_q, fault_d;

  logic hs;
  logic len_bad;
  logic pc_bad;

  assign s_ready    = (state_q == StLoad);
  assign hs         = s_valid & s_ready;
  assign len_bad    = (load_len == '0) || ({1'b0, load_len} > DepthLen);
  assign pc_bad     = (core_pc[1:0] != 2'b00) || ({1'b0, core_pc} > PcMax);

  assign core_stall = (state_q != StRun);
  assign mem_raddr  = (state_q == StRun) ? core_pc : '0;
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign fetch_fault = fault_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    count_d = count_q;
    csum_d  = csum_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      StHalt, StRun: begin
        if (load_start) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end else begin
            err_d   = 1'b0;
            count_d = load_len;
            csum_d  = load_csum;
            ptr_d   = '0;
            sum_d   = '0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = s_data;
          // A full-depth image wraps the pointer to 0; the FSM leaves LOAD on the same
          // handshake, so no write follows.
          ptr_d   = ptr_q + 1'b1;
          sum_d   = sum_q + s_data;
          count_d = count_q - 1'b1;
          if (count_q == LEN_W'(1)) state_d = StCheck;
        end
      end
      StCheck: begin
        if (sum_q == csum_q) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end
      default: state_d = StHalt;
    endcase
    // Only flag while RUN persists, so the flag is never visible outside RUN.
    fault_d = (state_q == StRun) && (state_d == StRun) && pc_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHalt;
      ptr_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

endmodule
